// File: rtl/keycode_decoder.sv
// Stability-filtered keycode decoder: qualifies key changes, tracks octave and
// waveform selection, and emits a registered tone divisor with note strobes.
module keycode_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIV_W         = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [3:0]       keycode,
  input  logic             mode_edge,
  input  logic             sound_edge,
  output logic [DIV_W-1:0] divisor,
  output logic             note_active,
  output logic             note_on,
  output logic             note_off,
  output logic [1:0]       octave,
  output logic [1:0]       wave_sel
);

  // state   | meaning
  // SILENT  | no accepted note; divisor forced to 0
  // PLAYING | accepted note held; divisor tracks key and octave
  typedef enum logic {SILENT, PLAYING} state_t;

  localparam logic [3:0]  KEY_NONE = 4'hF;
  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  state_t           state, state_next;
  logic [3:0]       key_norm;
  logic [3:0]       cand;
  logic [3:0]       acc;
  logic [3:0]       acc_next;
  logic [15:0]      cnt;
  logic             accept;
  logic             note_on_next;
  logic             note_off_next;
  logic [DIV_W-1:0] divisor_next;

  // Full-period counts at octave 0 for a 10 MHz clock, C(low)..C(high).
  function automatic logic [15:0] base_period(input logic [3:0] key);
    case (key)
      4'd0:    base_period = 16'd38223;
      4'd1:    base_period = 16'd36077;
      4'd2:    base_period = 16'd34052;
      4'd3:    base_period = 16'd32141;
      4'd4:    base_period = 16'd30337;
      4'd5:    base_period = 16'd28635;
      4'd6:    base_period = 16'd27027;
      4'd7:    base_period = 16'd25511;
      4'd8:    base_period = 16'd24079;
      4'd9:    base_period = 16'd22727;
      4'd10:   base_period = 16'd21452;
      4'd11:   base_period = 16'd20248;
      4'd12:   base_period = 16'd19111;
      default: base_period = 16'd0;
    endcase
  endfunction

  assign key_norm = (keycode > 4'd12) ? KEY_NONE : keycode;
  assign accept   = (key_norm == cand) && (cand != acc) && (cnt == CNT_LAST);
  assign acc_next = accept ? cand : acc;

  // Any change of the sampled key restarts the count; a revert to acc drops the pending change.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cand <= KEY_NONE;
      cnt  <= 16'd0;
      acc  <= KEY_NONE;
    end else if (key_norm != cand) begin
      cand <= key_norm;
      cnt  <= 16'd0;
    end else if (cand != acc) begin
      if (cnt == CNT_LAST) acc <= cand;
      else                 cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    state_next    = state;
    note_on_next  = 1'b0;
    note_off_next = 1'b0;
    case (state)
      SILENT: begin
        if (accept && (cand != KEY_NONE)) begin
          state_next   = PLAYING;
          note_on_next = 1'b1;
        end
      end
      PLAYING: begin
        if (accept) begin
          if (cand == KEY_NONE) begin
            state_next    = SILENT;
            note_off_next = 1'b1;
          end else begin
            note_on_next = 1'b1;
          end
        end
      end
      default: state_next = SILENT;
    endcase
    // Uses the registered octave, so an octave change lands one edge later.
    divisor_next = (state_next == PLAYING) ? DIV_W'(base_period(acc_next) >> octave) : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= SILENT;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      divisor  <= '0;
    end else begin
      state    <= state_next;
      note_on  <= note_on_next;
      note_off <= note_off_next;
      divisor  <= divisor_next;
    end
  end

  assign note_active = (state == PLAYING);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      octave   <= 2'd0;
      wave_sel <= 2'd0;
    end else begin
      if (mode_edge)  octave   <= (octave == 2'd2) ? 2'd0 : octave + 2'd1;
      if (sound_edge) wave_sel <= wave_sel + 2'd1;
    end
  end

endmodule

// File: tb/tb_keycode_decoder.sv
// Self-checking bench for keycode_decoder: directed scenarios plus a randomized
// run against a run-length based reference model.
module tb_keycode_decoder;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [3:0]  keycode = 4'hF;
  logic        mode_edge = 1'b0;
  logic        sound_edge = 1'b0;
  logic [15:0] divisor;
  logic        note_active, note_on, note_off;
  logic [1:0]  octave, wave_sel;

  int n_checks = 0;
  int n_pass = 0;

  int base_tbl[13] = '{38223, 36077, 34052, 32141, 30337, 28635, 27027,
                       25511, 24079, 22727, 21452, 20248, 19111};

  // Reference model: a key is accepted once it has been sampled S+1 times in a row.
  logic [3:0] m_last, m_acc;
  int         m_run, m_oct, m_wave, m_div;
  logic       m_on, m_off;

  keycode_decoder #(.STABLE_CYCLES(S), .DIV_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .keycode(keycode), .mode_edge(mode_edge),
    .sound_edge(sound_edge), .divisor(divisor), .note_active(note_active),
    .note_on(note_on), .note_off(note_off), .octave(octave), .wave_sel(wave_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_last = 4'hF; m_run = 1; m_acc = 4'hF;
    m_oct = 0; m_wave = 0; m_div = 0; m_on = 1'b0; m_off = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] k, input logic m, input logic s);
    logic [3:0] nk;
    nk = (k >= 4'd13) ? 4'hF : k;
    if (nk == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = nk;
      m_run = 1;
    end
    m_on = 1'b0; m_off = 1'b0;
    if (m_run >= S + 1 && nk != m_acc) begin
      m_acc = nk;
      if (nk == 4'hF) m_off = 1'b1;
      else            m_on = 1'b1;
    end
    m_div = (m_acc == 4'hF) ? 0 : (base_tbl[int'(m_acc)] >> m_oct);
    if (m) m_oct = (m_oct + 1) % 3;
    if (s) m_wave = (m_wave + 1) % 4;
  endfunction

  task automatic tick(input logic [3:0] k, input logic m, input logic s);
    keycode = k; mode_edge = m; sound_edge = s;
    @(posedge clk);
    model_step(k, m, s);
    #1;
    mode_edge = 1'b0; sound_edge = 1'b0;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({divisor, note_active, note_on, note_off, octave, wave_sel} !== 23'd0)
      $display("FAIL reset_state: got div=%0d act=%0b on=%0b off=%0b oct=%0d wave=%0d, expected all 0",
               divisor, note_active, note_on, note_off, octave, wave_sel);
    else n_pass++;
  endtask

  task automatic test_note_latency();
    for (int i = 1; i <= 10; i++) begin
      tick(4'd0, 1'b0, 1'b0);
      n_checks++;
      if (note_on !== (i == S + 1))
        $display("FAIL latency edge%0d: note_on=%0b expected %0b", i, note_on, (i == S + 1));
      else n_pass++;
    end
    n_checks++;
    if ({note_active, divisor, octave, note_off} !== {1'b1, 16'd38223, 2'd0, 1'b0})
      $display("FAIL first_note: act=%0b div=%0d oct=%0d off=%0b, expected 1 38223 0 0",
               note_active, divisor, octave, note_off);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic found, strobe;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(4'd9, 1'b0, 1'b0);
      if (note_on) found = 1'b1;
    end
    n_checks++;
    if (!found || divisor !== 16'd22727)
      $display("FAIL glitch_setup: found=%0b div=%0d, expected 1 22727", found, divisor);
    else n_pass++;
    strobe = 1'b0;
    tick(4'd4, 1'b0, 1'b0); strobe |= note_on | note_off;
    tick(4'd4, 1'b0, 1'b0); strobe |= note_on | note_off;
    for (int i = 0; i < 8; i++) begin
      tick(4'd9, 1'b0, 1'b0);
      strobe |= note_on | note_off;
    end
    n_checks++;
    if (strobe !== 1'b0 || divisor !== 16'd22727 || note_active !== 1'b1)
      $display("FAIL glitch: strobe=%0b div=%0d act=%0b, expected 0 22727 1", strobe, divisor, note_active);
    else n_pass++;
  endtask

  task automatic test_octave();
    logic strobe;
    strobe = 1'b0;
    tick(4'd9, 1'b1, 1'b0); strobe |= note_on | note_off;
    n_checks++;
    if (octave !== 2'd1) $display("FAIL octave_step1: octave=%0d expected 1", octave);
    else n_pass++;
    tick(4'd9, 1'b0, 1'b0); strobe |= note_on | note_off;
    tick(4'd9, 1'b1, 1'b0); strobe |= note_on | note_off;
    n_checks++;
    if (octave !== 2'd2 || divisor !== 16'd11363)
      $display("FAIL octave_lag: oct=%0d div=%0d, expected 2 11363", octave, divisor);
    else n_pass++;
    tick(4'd9, 1'b0, 1'b0); strobe |= note_on | note_off;
    n_checks++;
    if (divisor !== 16'd5681) $display("FAIL octave2_div: div=%0d expected 5681", divisor);
    else n_pass++;
    tick(4'd9, 1'b1, 1'b0); strobe |= note_on | note_off;
    tick(4'd9, 1'b0, 1'b0); strobe |= note_on | note_off;
    n_checks++;
    if (octave !== 2'd0 || divisor !== 16'd22727 || strobe !== 1'b0)
      $display("FAIL octave_wrap: oct=%0d div=%0d strobe=%0b, expected 0 22727 0", octave, divisor, strobe);
    else n_pass++;
  endtask

  task automatic test_legato();
    logic found;
    int ons, offs, off_div;
    logic off_act, on_seen;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(4'd0, 1'b0, 1'b0);
      if (note_on) found = 1'b1;
    end
    n_checks++;
    if (!found || divisor !== 16'd38223)
      $display("FAIL legato_setup: found=%0b div=%0d, expected 1 38223", found, divisor);
    else n_pass++;
    ons = 0; offs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'd12, 1'b0, 1'b0);
      ons += int'(note_on); offs += int'(note_off);
    end
    n_checks++;
    if (ons != 1 || offs != 0 || divisor !== 16'd19111 || note_active !== 1'b1)
      $display("FAIL legato: ons=%0d offs=%0d div=%0d act=%0b, expected 1 0 19111 1", ons, offs, divisor, note_active);
    else n_pass++;
    off_div = -1; off_act = 1'b1; on_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(4'hF, 1'b0, 1'b0);
      on_seen |= note_on;
      n_checks++;
      if (note_off !== (i == S + 1))
        $display("FAIL release edge%0d: note_off=%0b expected %0b", i, note_off, (i == S + 1));
      else n_pass++;
      if (i == S + 1) begin off_div = int'(divisor); off_act = note_active; end
    end
    n_checks++;
    if (off_div != 0 || off_act !== 1'b0 || on_seen !== 1'b0)
      $display("FAIL release_state: div=%0d act=%0b on_seen=%0b, expected 0 0 0", off_div, off_act, on_seen);
    else n_pass++;
  endtask

  task automatic test_invalid_codes();
    logic changed;
    apply_reset();
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(4'd13, 1'b0, 1'b0);
      changed |= note_on | note_off | note_active | (divisor != 16'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(4'd14, 1'b0, 1'b0);
      changed |= note_on | note_off | note_active | (divisor != 16'd0);
    end
    n_checks++;
    if (changed !== 1'b0) $display("FAIL invalid_codes: outputs changed=%0b expected 0", changed);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick(4'd13, 1'b0, 1'b1);
      tick(4'd13, 1'b0, 1'b0);
    end
    n_checks++;
    if (wave_sel !== 2'd1 || octave !== 2'd0)
      $display("FAIL wave_wrap: wave=%0d oct=%0d, expected 1 0", wave_sel, octave);
    else n_pass++;
  endtask

  task automatic test_reset_mid_note();
    logic found, off_seen;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(4'd4, 1'b0, 1'b0);
      if (note_on) found = 1'b1;
    end
    tick(4'd4, 1'b1, 1'b1);
    tick(4'd4, 1'b0, 1'b0);
    n_checks++;
    if (!found || divisor !== 16'd15168 || octave !== 2'd1 || wave_sel !== 2'd1)
      $display("FAIL midnote_setup: found=%0b div=%0d oct=%0d wave=%0d, expected 1 15168 1 1",
               found, divisor, octave, wave_sel);
    else n_pass++;
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({divisor, note_active, note_on, note_off, octave, wave_sel} !== 23'd0)
      $display("FAIL async_reset: div=%0d act=%0b on=%0b off=%0b oct=%0d wave=%0d, expected all 0",
               divisor, note_active, note_on, note_off, octave, wave_sel);
    else n_pass++;
    model_reset();
    off_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      off_seen |= note_off;
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(4'd4, 1'b0, 1'b0);
      off_seen |= note_off;
      n_checks++;
      if (note_on !== (i == S + 1))
        $display("FAIL post_reset edge%0d: note_on=%0b expected %0b", i, note_on, (i == S + 1));
      else n_pass++;
    end
    n_checks++;
    if (divisor !== 16'd30337 || note_active !== 1'b1 || off_seen !== 1'b0)
      $display("FAIL post_reset_state: div=%0d act=%0b off_seen=%0b, expected 30337 1 0", divisor, note_active, off_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  k;
    int          hold;
    logic        m, s;
    logic [22:0] got, exp;
    apply_reset();
    k = 4'hF; hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        k = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end
      hold--;
      m = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 7) == 0);
      tick(k, m, s);
      got = {divisor, note_active, note_on, note_off, octave, wave_sel};
      exp = {16'(m_div), (m_acc != 4'hF), m_on, m_off, 2'(m_oct), 2'(m_wave)};
      n_checks++;
      if (got !== exp)
        $display("FAIL random cycle%0d: div=%0d act=%0b on=%0b off=%0b oct=%0d wave=%0d, expected div=%0d act=%0b on=%0b off=%0b oct=%0d wave=%0d",
                 c, got[22:7], got[6], got[5], got[4], got[3:2], got[1:0],
                 exp[22:7], exp[6], exp[5], exp[4], exp[3:2], exp[1:0]);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_note_latency();
    test_glitch();
    test_octave();
    test_legato();
    test_invalid_codes();
    test_reset_mid_note();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keycode_decoder.md
Name: keycode_decoder

Overview:
Consumer end of the keypad interface. Takes the one-hot-priority keycode plus mode/sound edge pulses from the keypad front end and qualifies key changes with a stability filter. Tracks the octave and waveform selection and emits a registered tone divisor with note-on/note-off strobes. Sits between the keypad front end and the oscillator/waveform generator.

Parameters:
STABLE_CYCLES, 4, consecutive clk cycles a new keycode must hold before acceptance (legal range 1..65535)
DIV_W, 16, width of the period divisor output

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
keycode  input  4  0..12 = note C(low)..C(high); 4'hF = no key; 13/14 treated as 4'hF
mode_edge  input  1  single-cycle pulse; advances octave
sound_edge  input  1  single-cycle pulse; advances waveform
divisor  output  DIV_W  full-period count of accepted note at current octave; 0 when silent
note_active  output  1  high while an accepted note is held
note_on  output  1  one-cycle pulse when an accepted note starts or changes pitch key
note_off  output  1  one-cycle pulse when the accepted note is released
octave  output  2  0,1,2
wave_sel  output  2  0 square, 1 saw, 2 triangle, 3 sine

Behaviour:
- Reset n_rst, asynchronous, active-low; clock clk. All state clears on reset: divisor 0, note_active 0, note_on 0, note_off 0, octave 0, wave_sel 0, candidate = 4'hF, accepted = 4'hF, stable counter 0.
- Normalise: codes 13, 14, 15 all map to NONE (4'hF) before any comparison.
- Filter: registers cand, cnt, acc. Each edge: if norm keycode != cand -> cand <= keycode, cnt <= 0. Else if cand != acc: if cnt == STABLE_CYCLES-1 accept (acc <= cand), else cnt++. Else cnt holds.
- Latency: a keycode first sampled at edge N, held steady, is accepted at edge N+STABLE_CYCLES; outputs change at that same edge (registered). Glitch shorter than STABLE_CYCLES cycles never reaches outputs; reverting to acc clears pending change.
- FSM, states SILENT / PLAYING:
  SILENT -> PLAYING on accept of a note key: note_on=1 for one cycle, note_active=1.
  PLAYING -> PLAYING on accept of a different note key (legato): note_on=1, note_off stays 0, divisor updates.
  PLAYING -> SILENT on accept of NONE: note_off=1 for one cycle, note_active=0, divisor=0.
  note_on and note_off are never high together.
- Base table (octave 0, 10 MHz clk full periods), keys 0..12: 38223, 36077, 34052, 32141, 30337, 28635, 27027, 25511, 24079, 22727, 21452, 20248, 19111.
- divisor = table[acc] >> octave (logical shift, truncating) while PLAYING; 0 in SILENT. Registered; recomputed every cycle.
- octave: mode_edge advances 0->1->2->0. wave_sel: sound_edge advances 0->1->2->3->0 (natural 2-bit wrap).
- octave/wave_sel update at the edge sampling the pulse. divisor reflects a new octave one edge later; this includes octave changes while a note is held, which cause no note_on.
- Simultaneous events: mode_edge, sound_edge and key acceptance in one cycle are independent; all take effect.
- Reset mid-note: immediate silence; no note_off pulse emitted.

Test Plan:
- Reset, keycode=0 held 10 cycles -> note_on pulse exactly 4 edges after first sample, note_active=1, divisor=38223, octave=0.
- Key 9 held, 2-cycle glitch to key 4 then back -> no note_on/note_off, divisor stays 22727.
- Key 9 held, pulse mode_edge twice -> octave=2, divisor=5681, no note_on. Third pulse -> octave=0, divisor=22727.
- Key 0 -> key 12 legato -> single note_on, note_off never asserted, divisor 38223 -> 19111. Then keycode=4'hF -> note_off one cycle, divisor=0, note_active=0.
- keycode=13 from SILENT, held 20 cycles -> no outputs change. Pulse sound_edge 5 times -> wave_sel=1.
- Key 4 playing, assert n_rst mid-note -> all outputs 0 immediately. Release reset with key 4 still held -> note_on again after 4 cycles, divisor=30337.
